// File: rtl/vector_alu_seq_pkg.sv
// Shared types and constants for the vector ALU issue/writeback sequencer.
package vector_alu_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_WAIT,
      ST_DONE
   } seq_state_t;

   typedef enum logic [1:0] {
      WW_8  = 2'b00,
      WW_16 = 2'b01,
      WW_32 = 2'b10,
      WW_64 = 2'b11
   } ww_t;

   localparam logic [3:0] FN_VMULEU = 4'b0111;
   localparam logic [3:0] FN_VMULOU = 4'b1000;

   // Must hold MUL_LAT-1 without wrapping.
   function automatic int seq_cnt_width(input int mul_lat);
      return $clog2(mul_lat) + 1;
   endfunction

   // 64-bit element multiplies are single-cycle in this ALU.
   function automatic logic is_multiply(input logic [3:0] op, input logic [1:0] ww);
      return ((op == FN_VMULEU) || (op == FN_VMULOU)) && (ww != WW_64);
   endfunction

endpackage

// File: rtl/vector_alu_seq_hazard.sv
// Compares incoming source registers against the in-flight destination.
module vector_alu_seq_hazard
   import vector_alu_seq_pkg::*;
(
   input  logic [0:4] src_a,
   input  logic [0:4] src_b,
   input  logic [0:4] dest,
   output logic       match_a,
   output logic       match_b
);

   assign match_a = (src_a == dest);
   assign match_b = (src_b == dest);

endmodule

// File: rtl/vector_alu_sequencer.sv
// Issue/writeback scheduler for the 64-bit vector ALU.
// Define ALU_SEQ_FWD_EN to forward the held ALU result instead of stalling on a RAW hazard.
module vector_alu_sequencer
   import vector_alu_seq_pkg::*;
#(
   parameter int MUL_LAT = 3
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic       ID_valid,
   output logic       ID_ready,
   input  logic [0:5] ID_function_bit,
   input  logic [0:4] ID_PPPWW,
   input  logic [0:4] ID_rD,
   input  logic [0:4] ID_rA,
   input  logic [0:4] ID_rB,
   output logic       ALU_enable,
   output logic [0:5] SEQ_function_bit,
   output logic [0:4] SEQ_PPPWW,
   output logic [0:4] SEQ_rD,
   output logic       WB_valid,
   input  logic       WB_ready,
   output logic [0:4] WB_rD,
   output logic       FWD_A,
   output logic       FWD_B
);

   localparam int               CNT_W    = seq_cnt_width(MUL_LAT);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_LAT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   seq_state_t       state;
   seq_state_t       state_next;
   logic [CNT_W-1:0] cnt;
   logic             match_a;
   logic             match_b;
   logic             hazard;
   logic             stall;
   logic             accept;
   logic             exec_mul;

   vector_alu_seq_hazard u_hazard (
      .src_a   (ID_rA),
      .src_b   (ID_rB),
      .dest    (SEQ_rD),
      .match_a (match_a),
      .match_b (match_b)
   );

   assign hazard   = (state == ST_DONE) && (match_a || match_b);
   assign ID_ready = (state == ST_IDLE) || ((state == ST_DONE) && WB_ready && !stall);
   assign accept   = ID_valid && ID_ready;
   assign exec_mul = is_multiply(SEQ_function_bit[2:5], SEQ_PPPWW[3:4]) && (MUL_LAT > 1);

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE: if (accept) state_next = ST_EXEC;
         ST_EXEC: state_next = exec_mul ? ST_WAIT : ST_DONE;
         ST_WAIT: if (cnt == CNT_LAST) state_next = ST_DONE;
         ST_DONE: if (WB_ready) state_next = accept ? ST_EXEC : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state            <= ST_IDLE;
         cnt              <= '0;
         SEQ_function_bit <= '0;
         SEQ_PPPWW        <= '0;
         SEQ_rD           <= '0;
      end else begin
         state <= state_next;
         if (accept) begin
            SEQ_function_bit <= ID_function_bit;
            SEQ_PPPWW        <= ID_PPPWW;
            SEQ_rD           <= ID_rD;
         end
         if ((state == ST_EXEC) && exec_mul) begin
            cnt <= CNT_LOAD;
         end else if (state == ST_WAIT) begin
            cnt <= cnt - CNT_LAST;
         end
      end
   end

`ifdef ALU_SEQ_FWD_EN
   logic fwd_a_q;
   logic fwd_b_q;

   // Selects live for the single EXEC cycle that follows an accept out of DONE.
   always_ff @(posedge clk) begin
      if (reset || !accept) begin
         fwd_a_q <= 1'b0;
         fwd_b_q <= 1'b0;
      end else begin
         fwd_a_q <= hazard && match_a;
         fwd_b_q <= hazard && match_b;
      end
   end

   assign stall = 1'b0;
   assign FWD_A = fwd_a_q;
   assign FWD_B = fwd_b_q;
`else
   assign stall = hazard;
   assign FWD_A = 1'b0;
   assign FWD_B = 1'b0;
`endif

   assign ALU_enable = (state == ST_EXEC);
   assign WB_valid   = (state == ST_DONE);
   assign WB_rD      = WB_valid ? SEQ_rD : '0;

endmodule

// File: tb/tb_vector_alu_sequencer.sv
// Self-checking bench for vector_alu_sequencer: directed scenarios plus random traffic
// against a timestamp-based transaction model (honours ALU_SEQ_FWD_EN).
module tb_vector_alu_sequencer;

   localparam int MUL_LAT = 3;

   logic       clk = 1'b0;
   logic       reset;
   logic       id_valid;
   logic       id_ready;
   logic [0:5] id_function_bit;
   logic [0:4] id_pppww;
   logic [0:4] id_rd;
   logic [0:4] id_ra;
   logic [0:4] id_rb;
   logic       alu_enable;
   logic [0:5] seq_function_bit;
   logic [0:4] seq_pppww;
   logic [0:4] seq_rd;
   logic       wb_valid;
   logic       wb_ready;
   logic [0:4] wb_rd;
   logic       fwd_a;
   logic       fwd_b;

   always #5 clk = ~clk;

   vector_alu_sequencer #(.MUL_LAT(MUL_LAT)) dut (
      .clk              (clk),
      .reset            (reset),
      .ID_valid         (id_valid),
      .ID_ready         (id_ready),
      .ID_function_bit  (id_function_bit),
      .ID_PPPWW         (id_pppww),
      .ID_rD            (id_rd),
      .ID_rA            (id_ra),
      .ID_rB            (id_rb),
      .ALU_enable       (alu_enable),
      .SEQ_function_bit (seq_function_bit),
      .SEQ_PPPWW        (seq_pppww),
      .SEQ_rD           (seq_rd),
      .WB_valid         (wb_valid),
      .WB_ready         (wb_ready),
      .WB_rD            (wb_rd),
      .FWD_A            (fwd_a),
      .FWD_B            (fwd_b)
   );

   int checks;
   int errors;
   int cyc;

   // Model: an in-flight op is described by its issue cycle and the cycle its result appears.
   bit         m_known;
   bit         m_busy;
   int         m_issue;
   int         m_done;
   logic [0:5] m_fn;
   logic [0:4] m_pw;
   logic [0:4] m_rd;
   bit         m_fwd_a;
   bit         m_fwd_b;

   logic       s_en;
   logic       s_wbv;
   logic       s_rdy;
   logic       s_fa;
   logic       s_fb;
   logic [0:4] s_wbrd;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, actual, expected, cyc);
      end
   endtask

   task automatic applyStimulus(input bit rst, input bit valid, input bit wbr,
                                input logic [0:5] fn, input logic [0:4] pw,
                                input logic [0:4] rd, input logic [0:4] ra, input logic [0:4] rb);
      bit         e_en;
      bit         e_wbv;
      bit         e_haz;
      bit         e_stall;
      bit         e_rdy;
      bit         acc;
      bit         mul;
      logic [3:0] op;
      logic [1:0] ww;

      reset           = rst;
      id_valid        = valid;
      wb_ready        = wbr;
      id_function_bit = fn;
      id_pppww        = pw;
      id_rd           = rd;
      id_ra           = ra;
      id_rb           = rb;
      #1;

      e_en  = m_busy && (cyc == m_issue);
      e_wbv = m_busy && (cyc >= m_done);
      e_haz = e_wbv && ((ra == m_rd) || (rb == m_rd));
`ifdef ALU_SEQ_FWD_EN
      e_stall = 1'b0;
`else
      e_stall = e_haz;
`endif
      e_rdy = !m_busy || (e_wbv && wbr && !e_stall);

      s_en   = alu_enable;
      s_wbv  = wb_valid;
      s_rdy  = id_ready;
      s_fa   = fwd_a;
      s_fb   = fwd_b;
      s_wbrd = wb_rd;

      if (m_known) begin
         checkOutput("id_ready",   32'(id_ready),         32'(e_rdy));
         checkOutput("alu_enable", 32'(alu_enable),       32'(e_en));
         checkOutput("wb_valid",   32'(wb_valid),         32'(e_wbv));
         checkOutput("wb_rd",      32'(wb_rd),            e_wbv ? 32'(m_rd) : 32'd0);
         checkOutput("seq_fn",     32'(seq_function_bit), 32'(m_fn));
         checkOutput("seq_pppww",  32'(seq_pppww),        32'(m_pw));
         checkOutput("seq_rd",     32'(seq_rd),           32'(m_rd));
         checkOutput("fwd_a",      32'(fwd_a),            32'(e_en && m_fwd_a));
         checkOutput("fwd_b",      32'(fwd_b),            32'(e_en && m_fwd_b));
      end

      acc = valid && e_rdy;
      op  = fn[2:5];
      ww  = pw[3:4];
      mul = ((op == 4'b0111) || (op == 4'b1000)) && (ww != 2'b11);

      if (rst) begin
         m_known = 1'b1;
         m_busy  = 1'b0;
         m_fn    = '0;
         m_pw    = '0;
         m_rd    = '0;
         m_fwd_a = 1'b0;
         m_fwd_b = 1'b0;
      end else if (m_known) begin
         if (acc) begin
`ifdef ALU_SEQ_FWD_EN
            m_fwd_a = e_wbv && (ra == m_rd);
            m_fwd_b = e_wbv && (rb == m_rd);
`else
            m_fwd_a = 1'b0;
            m_fwd_b = 1'b0;
`endif
            m_busy  = 1'b1;
            m_issue = cyc + 1;
            m_done  = cyc + 1 + (mul ? MUL_LAT : 1);
            m_fn    = fn;
            m_pw    = pw;
            m_rd    = rd;
         end else if (e_wbv && wbr) begin
            m_busy = 1'b0;
         end
      end

      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idleCycle(input bit wbr);
      applyStimulus(1'b0, 1'b0, wbr, 6'd0, 5'd0, 5'd0, 5'd30, 5'd31);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      cyc     = 0;
      m_known = 1'b0;
      m_busy  = 1'b0;
      m_issue = 0;
      m_done  = 0;
      m_fn    = '0;
      m_pw    = '0;
      m_rd    = '0;
      m_fwd_a = 1'b0;
      m_fwd_b = 1'b0;
      @(posedge clk);
      #1;

      // Reset held two cycles with a valid instruction waiting.
      applyStimulus(1'b1, 1'b1, 1'b1, 6'b000101, 5'b00011, 5'd5, 5'd1, 5'd2);
      applyStimulus(1'b1, 1'b1, 1'b1, 6'b000101, 5'b00011, 5'd5, 5'd1, 5'd2);
      checkOutput("rst_ready", 32'(s_rdy), 32'd1);
      checkOutput("rst_wbv",   32'(s_wbv), 32'd0);
      idleCycle(1'b1);
      checkOutput("rst_no_accept", 32'(s_en), 32'd0);

      // Single-cycle VADD.
      applyStimulus(1'b0, 1'b1, 1'b1, 6'b000101, 5'b00011, 5'd5, 5'd1, 5'd2);
      checkOutput("vadd_accept", 32'(s_rdy), 32'd1);
      idleCycle(1'b1);
      checkOutput("vadd_c1_en", 32'(s_en), 32'd1);
      idleCycle(1'b1);
      checkOutput("vadd_c2_en",  32'(s_en),   32'd0);
      checkOutput("vadd_c2_wbv", 32'(s_wbv),  32'd1);
      checkOutput("vadd_c2_rd",  32'(s_wbrd), 32'd5);
      idleCycle(1'b1);
      checkOutput("vadd_c3_idle", 32'(s_rdy), 32'd1);

      // VMULEU latency.
      applyStimulus(1'b0, 1'b1, 1'b1, 6'b000111, 5'b00000, 5'd9, 5'd1, 5'd2);
      for (int k = 1; k <= MUL_LAT + 1; k++) begin
         idleCycle(1'b1);
         checkOutput("mul_wbv", 32'(s_wbv), 32'(k == MUL_LAT + 1));
         if (k <= MUL_LAT) checkOutput("mul_busy_rdy", 32'(s_rdy), 32'd0);
      end
      idleCycle(1'b1);

      // Writeback backpressure.
      applyStimulus(1'b0, 1'b1, 1'b1, 6'b000101, 5'b00010, 5'd12, 5'd1, 5'd2);
      applyStimulus(1'b0, 1'b1, 1'b0, 6'b000011, 5'b00001, 5'd13, 5'd1, 5'd2);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 6'b000011, 5'b00001, 5'd13, 5'd1, 5'd2);
         checkOutput("bp_wbv", 32'(s_wbv),  32'd1);
         checkOutput("bp_rd",  32'(s_wbrd), 32'd12);
         checkOutput("bp_en",  32'(s_en),   32'd0);
         checkOutput("bp_rdy", 32'(s_rdy),  32'd0);
      end
      idleCycle(1'b1);
      checkOutput("bp_release", 32'(s_wbv), 32'd1);
      idleCycle(1'b1);
      checkOutput("bp_idle", 32'(s_wbv), 32'd0);

      // Dependent pair: VAND rD=7 then VOR rA=7.
      applyStimulus(1'b0, 1'b1, 1'b1, 6'b000001, 5'b00011, 5'd7, 5'd1, 5'd2);
      applyStimulus(1'b0, 1'b1, 1'b1, 6'b000010, 5'b00011, 5'd8, 5'd7, 5'd3);
      applyStimulus(1'b0, 1'b1, 1'b1, 6'b000010, 5'b00011, 5'd8, 5'd7, 5'd3);
`ifdef ALU_SEQ_FWD_EN
      checkOutput("dep_done_accept", 32'(s_rdy), 32'd1);
      idleCycle(1'b1);
      checkOutput("dep_en",  32'(s_en), 32'd1);
      checkOutput("dep_fwa", 32'(s_fa), 32'd1);
      checkOutput("dep_fwb", 32'(s_fb), 32'd0);
`else
      checkOutput("dep_stall", 32'(s_rdy), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 6'b000010, 5'b00011, 5'd8, 5'd7, 5'd3);
      checkOutput("dep_idle_accept", 32'(s_rdy), 32'd1);
      idleCycle(1'b1);
      checkOutput("dep_en",  32'(s_en), 32'd1);
      checkOutput("dep_fwa", 32'(s_fa), 32'd0);
`endif
      idleCycle(1'b1);
      idleCycle(1'b1);

      // Reset in the second WAIT cycle of VMULOU.
      applyStimulus(1'b0, 1'b1, 1'b1, 6'b001000, 5'b00001, 5'd10, 5'd1, 5'd2);
      idleCycle(1'b1);
      idleCycle(1'b1);
      applyStimulus(1'b1, 1'b0, 1'b1, 6'd0, 5'd0, 5'd0, 5'd30, 5'd31);
      idleCycle(1'b1);
      checkOutput("rstmid_rdy", 32'(s_rdy),  32'd1);
      checkOutput("rstmid_en",  32'(s_en),   32'd0);
      checkOutput("rstmid_wbv", 32'(s_wbv),  32'd0);
      checkOutput("rstmid_rd",  32'(s_wbrd), 32'd0);
      for (int k = 0; k < 5; k++) begin
         idleCycle(1'b1);
         checkOutput("rstmid_no_wb", 32'(s_wbv), 32'd0);
      end

      // Random traffic with small register range to provoke hazards.
      for (int n = 0; n < 3000; n++) begin
         logic [3:0] op;
         int         sel;
         sel = int'($urandom_range(0, 3));
         op  = (sel == 0) ? 4'b0111 : (sel == 1) ? 4'b1000 : 4'($urandom);
         applyStimulus($urandom_range(0, 63) == 0,
                       $urandom_range(0, 9) < 7,
                       $urandom_range(0, 9) < 6,
                       {2'($urandom), op},
                       5'($urandom),
                       5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)),
                       5'($urandom_range(0, 7)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
